// File: rtl/cpu_pipe_pkg.sv
// Shared types and widths for the CPU front-end pipeline.
package cpu_pipe_pkg;

    localparam int unsigned PC_W    = 16;
    localparam int unsigned INSTR_W = 16;

    typedef enum logic [1:0] {
        FLUSH_NONE   = 2'b00,
        FLUSH_BUBBLE = 2'b01,
        FLUSH_KILL   = 2'b10
    } flush_t;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {pc, instr} entries with a single-cycle clear.
module fetch_queue
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned Depth = 2,
    parameter int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  fetch_entry_t    push_data_i,
    input  logic            pop_i,
    input  logic            clear_i,
    output fetch_entry_t    head_o,
    output logic [CntW-1:0] count_o,
    output logic            empty_o,
    output logic            full_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    fetch_entry_t    mem_q [Depth];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(Depth));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        count_d  = count_q + CntW'(do_push) - CntW'(do_pop);
        if (clear_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues credit-limited memory requests,
// queues responses and drops those made stale by a branch redirect.
module fetch_unit
    import cpu_pipe_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int unsigned     QDEPTH   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [PC_W-1:0]    imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] instruction,
    output logic [1:0]         flush
);

    localparam int unsigned   CntW      = $clog2(QDEPTH + 1);
    localparam logic [CntW:0] CreditMax = (CntW + 1)'(QDEPTH);

    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0] rsp_pc_q, rsp_pc_d;
    logic [CntW-1:0] inflight_q, inflight_d;
    logic [CntW-1:0] drop_q, drop_d;
    logic            boot_q;

    fetch_entry_t    q_head;
    logic [CntW-1:0] q_count;
    logic            q_empty, q_full, q_push, q_pop;
    logic            accept;

    fetch_queue #(
        .Depth(QDEPTH),
        .CntW (CntW)
    ) u_queue (
        .clk_i      (clk),
        .rst_i      (reset),
        .push_i     (q_push),
        .push_data_i('{pc: rsp_pc_q, instr: imem_rsp_data}),
        .pop_i      (q_pop),
        .clear_i    (branch_taken),
        .head_o     (q_head),
        .count_o    (q_count),
        .empty_o    (q_empty),
        .full_o     (q_full)
    );

    // Credits count stale requests too, so the queue can never overflow.
    assign imem_req_valid = !reset && !boot_q && !branch_taken
                            && (({1'b0, inflight_q} + {1'b0, q_count}) < CreditMax);
    assign imem_req_addr  = fetch_pc_q;
    assign accept         = imem_req_valid && imem_req_ready;

    always_comb begin
        q_push = !reset && !branch_taken && imem_rsp_valid && (drop_q == '0) && !q_full;
        q_pop  = !reset && !branch_taken && !stall && !q_empty;

        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        inflight_d = inflight_q + CntW'(accept) - CntW'(imem_rsp_valid);
        drop_d     = drop_q;

        if (branch_taken) begin
            fetch_pc_d = branch_target;
            rsp_pc_d   = branch_target;
            // Every request still outstanding after this edge belongs to the old path.
            drop_d     = inflight_q - CntW'(imem_rsp_valid);
        end else begin
            if (accept) fetch_pc_d = fetch_pc_q + PC_W'(1);
            if (q_push) rsp_pc_d = rsp_pc_q + PC_W'(1);
            if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CntW'(1);
        end
    end

    always_comb begin
        pc          = rsp_pc_q;
        instruction = '0;
        flush       = FLUSH_BUBBLE;
        if (reset) begin
            pc = RESET_PC;
        end else begin
            if (!q_empty) begin
                pc          = q_head.pc;
                instruction = q_head.instr;
                flush       = FLUSH_NONE;
            end
            if (branch_taken) begin
                instruction = '0;
                flush       = FLUSH_KILL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            boot_q     <= 1'b1;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            boot_q     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic against a stream-level model.
module tb_fetch_unit;

    localparam int QD = 2;

    logic        clk = 1'b0;
    logic        reset, stall, branch_taken, imem_req_ready, imem_rsp_valid;
    logic [15:0] branch_target, imem_rsp_data, imem_req_addr, pc, instruction;
    logic        imem_req_valid;
    logic [1:0]  flush;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC(16'h0000),
        .QDEPTH  (QD)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .pc            (pc),
        .instruction   (instruction),
        .flush         (flush)
    );

    typedef struct {
        logic [15:0] addr;
        int          due;
        bit          stale;
    } req_t;

    req_t        pend[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          occ = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    logic [15:0] exp_pc, exp_req;
    bit          post_reset;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0;
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 16'h0;
        for (int i = 0; i < 2; i++) begin
            #4;
            check("rst_req_valid", 32'(imem_req_valid), 32'd0);
            check("rst_pc", 32'(pc), 32'd0);
            check("rst_instr", 32'(instruction), 32'd0);
            check("rst_flush", 32'(flush), 32'd1);
            @(posedge clk); #1;
            cyc++;
        end
        reset = 1'b0;
        pend.delete();
        occ = 0; exp_pc = 16'h0; exp_req = 16'h0; post_reset = 1'b1;
    endtask

    // One clock: memory model drives the response, outputs are checked, then the model advances.
    task automatic step(input bit st, input bit br, input logic [15:0] tgt, input bit rdy);
        bit          rv, live, ev;
        logic [15:0] rd;
        logic [1:0]  ef;
        int          infl;
        infl = pend.size();
        rv = 1'b0; rd = 16'h0; live = 1'b0;
        if (infl > 0 && pend[0].due <= cyc) begin
            rv   = 1'b1;
            rd   = pend[0].addr ^ 16'hA000;
            live = !pend[0].stale && !br;
            pend.delete(0);
        end
        stall = st; branch_taken = br; branch_target = tgt; imem_req_ready = rdy;
        imem_rsp_valid = rv; imem_rsp_data = rd;
        ev = !br && !post_reset && (infl + occ) < QD;
        ef = br ? 2'b10 : ((occ > 0) ? 2'b00 : 2'b01);
        #4;
        check("req_valid", 32'(imem_req_valid), 32'(ev));
        if (ev) check("req_addr", 32'(imem_req_addr), 32'(exp_req));
        check("flush", 32'(flush), 32'(ef));
        check("pc", 32'(pc), 32'(exp_pc));
        check("instr", 32'(instruction), (ef == 2'b00) ? 32'(exp_pc ^ 16'hA000) : 32'd0);
        @(posedge clk); #1;
        if (ev && rdy) begin
            pend.push_back('{exp_req, cyc + int'($urandom_range(lat_max, lat_min)), 1'b0});
            exp_req++;
        end
        if (br) begin
            foreach (pend[i]) pend[i].stale = 1'b1;
            occ = 0; exp_pc = tgt; exp_req = tgt;
        end else begin
            if (occ > 0 && !st) begin
                occ--;
                exp_pc++;
            end
            if (live) occ++;
        end
        post_reset = 1'b0;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 1'b1);
    endtask

    initial begin
        do_reset();

        // Plain fetch from reset with single-cycle memory
        lat_min = 1; lat_max = 1;
        run(4);
        for (int i = 0; i < 30 && !(occ > 0 && exp_pc == 16'd5); i++) run(1);
        check("reach_pc5", 32'(occ > 0 && exp_pc == 16'd5), 32'd1);

        // Hold pc 5 under stall
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0, 1'b1);
        run(3);

        // Redirect with two requests outstanding
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 40 && pend.size() != 2; i++) run(1);
        check("two_inflight", 32'(pend.size()), 32'd2);
        step(1'b0, 1'b1, 16'h0040, 1'b1);
        for (int i = 0; i < 20 && !(occ > 0); i++) run(1);
        check("first_after_redirect", 32'(exp_pc), 32'h0040);
        run(4);

        // Redirect colliding with a response and a stall
        for (int i = 0; i < 40 && !(pend.size() == 2 && pend[0].due <= cyc); i++) run(1);
        check("rsp_in_redirect", 32'(pend.size() == 2 && pend[0].due <= cyc), 32'd1);
        step(1'b1, 1'b1, 16'h0100, 1'b1);
        run(10);

        // Memory not ready for four cycles
        lat_min = 1; lat_max = 2;
        run(3);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'h0, 1'b0);
        run(8);

        // PC wrap
        step(1'b0, 1'b1, 16'hFFFE, 1'b1);
        for (int i = 0; i < 30 && exp_pc != 16'h0002; i++) run(1);
        check("pc_wrapped", 32'(exp_pc), 32'h0002);

        // Random traffic with a mid-run reset
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 500; i++) begin
            if (i == 250) do_reset();
            step($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
                 16'($urandom), $urandom_range(0, 3) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
